// File: rtl/axis_packet_gen.sv
// axis_packet_gen: AXI-Stream packet generator with fixed/sweeping lengths, counter or PRBS31 payload,
// inter-packet gaps, bounded bursts, partial last-beat tkeep and traffic statistics.
module axis_packet_gen #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [30:0] PRBS_SEED  = 31'h7FFFFFFF,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                    m00_axis_aclk,
    input  logic                    m00_axis_aresetn,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic [15:0]             cfg_len_min,
    input  logic [15:0]             cfg_len_max,
    input  logic                    cfg_len_sweep,
    input  logic                    cfg_prbs,
    input  logic [DATA_WIDTH-17:0]  cfg_data,
    input  logic [15:0]             cfg_gap,
    input  logic [31:0]             cfg_pkt_count,
    input  logic [DATA_WIDTH/8-1:0] cfg_last_keep,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tkeep,
    output logic                    m00_axis_tvalid,
    input  logic                    m00_axis_tready,
    output logic                    m00_axis_tlast,
    output logic                    busy,
    output logic                    done,
    output logic                    perf_start,
    output logic [CNT_WIDTH-1:0]    stat_pkt_count,
    output logic [CNT_WIDTH-1:0]    stat_beat_count
);
    localparam int          KW   = DATA_WIDTH / 8;
    localparam int          PW   = DATA_WIDTH - 16;
    localparam logic [30:0] SEED = (PRBS_SEED == '0) ? '1 : PRBS_SEED;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    state_t state, state_nx;

    logic [15:0]    len_min_q, len_max_q, gap_q, len, beat, gap_cnt, lmin_q, len_nx;
    logic           sweep_q, prbs_q, stop_pending;
    logic [PW-1:0]  data_q, payload;
    logic [31:0]    pkt_cnt_q, pkt_num;
    logic [KW-1:0]  last_keep_q;
    logic [30:0]    lfsr;
    logic [16:0]    len_inc;
    logic           send, start, hs, last, hs_last, hit, stop_any, sweep_ok;

    assign send     = state == SEND;
    assign busy     = state == SEND || state == GAP;
    assign start    = cfg_start && (state == IDLE || state == DONE);
    assign last     = beat == len - 16'd1;
    assign hs       = send && m00_axis_tready;
    assign hs_last  = hs && last;
    assign hit      = pkt_cnt_q != '0 && pkt_num + 32'd1 == pkt_cnt_q;
    assign stop_any = stop_pending || cfg_stop;
    assign lmin_q   = (len_min_q == '0) ? 16'd1 : len_min_q;
    assign len_inc  = {1'b0, len} + 17'd1;
    assign sweep_ok = sweep_q && len_max_q >= lmin_q;
    assign len_nx   = (!sweep_ok || len_inc > {1'b0, len_max_q}) ? lmin_q : len_inc[15:0];

    // PRBS payload repeats the 31-bit LFSR state from its LSB upwards to fill the upper field
    always_comb begin
        payload = data_q;
        for (int i = 0; i < PW; i++)
            payload[i] = prbs_q ? lfsr[i % 31] : data_q[i];
    end

    assign m00_axis_tvalid = send;
    assign m00_axis_tlast  = send && last;
    assign m00_axis_tdata  = send ? {payload, beat} : '0;
    assign m00_axis_tkeep  = send ? ((last && last_keep_q != '0) ? last_keep_q : '1) : '0;

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = cfg_start ? SEND : state;
            SEND: if (hs_last) state_nx = hit ? DONE : stop_any ? IDLE : (gap_q != '0) ? GAP : SEND;
            GAP: state_nx = stop_any ? IDLE : (gap_cnt == gap_q - 16'd1) ? SEND : GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            len_min_q       <= '0;
            len_max_q       <= '0;
            sweep_q         <= 1'b0;
            prbs_q          <= 1'b0;
            data_q          <= '0;
            gap_q           <= '0;
            pkt_cnt_q       <= '0;
            last_keep_q     <= '0;
            len             <= '0;
            beat            <= '0;
            gap_cnt         <= '0;
            pkt_num         <= '0;
            lfsr            <= SEED;
            stop_pending    <= 1'b0;
            done            <= 1'b0;
            perf_start      <= 1'b0;
            stat_pkt_count  <= '0;
            stat_beat_count <= '0;
        end else if (start) begin
            len_min_q       <= cfg_len_min;
            len_max_q       <= cfg_len_max;
            sweep_q         <= cfg_len_sweep;
            prbs_q          <= cfg_prbs;
            data_q          <= cfg_data;
            gap_q           <= cfg_gap;
            pkt_cnt_q       <= cfg_pkt_count;
            last_keep_q     <= cfg_last_keep;
            len             <= (cfg_len_min == '0) ? 16'd1 : cfg_len_min;
            beat            <= '0;
            gap_cnt         <= '0;
            pkt_num         <= '0;
            lfsr            <= SEED;
            stop_pending    <= 1'b0;
            done            <= 1'b0;
            perf_start      <= 1'b0;
            stat_pkt_count  <= '0;
            stat_beat_count <= '0;
        end else begin
            // a stop only survives while the burst keeps running; leaving to IDLE/DONE consumes it
            stop_pending <= (state_nx == SEND || state_nx == GAP) && (stop_pending || (busy && cfg_stop));
            gap_cnt      <= (state == GAP) ? gap_cnt + 16'd1 : '0;
            perf_start   <= hs && beat == '0;
            if (hs) begin
                beat            <= last ? '0 : beat + 16'd1;
                lfsr            <= {lfsr[29:0], lfsr[30] ^ lfsr[27]};
                stat_beat_count <= stat_beat_count + CNT_WIDTH'(1);
            end
            if (hs_last) begin
                len            <= len_nx;
                pkt_num        <= pkt_num + 32'd1;
                stat_pkt_count <= stat_pkt_count + CNT_WIDTH'(1);
                done           <= hit;
            end
        end
    end
endmodule

// File: tb/tb_axis_packet_gen.sv
// tb_axis_packet_gen: directed bench for axis_packet_gen, 32-bit and 64-bit instances driven in parallel.
module tb_axis_packet_gen;
    logic        clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0, cfg_stop = 1'b0;
    logic        cfg_len_sweep = 1'b0, cfg_prbs = 1'b0, tready = 1'b1;
    logic [15:0] cfg_len_min = '0, cfg_len_max = '0, cfg_gap = '0;
    logic [47:0] cfg_data = '0;
    logic [31:0] cfg_pkt_count = '0;
    logic [7:0]  cfg_last_keep = '0;

    logic [31:0] d32_tdata, d32_spkt, d32_sbeat;
    logic [3:0]  d32_tkeep;
    logic        d32_tvalid, d32_tlast, d32_busy, d32_done, d32_perf;
    logic [63:0] d64_tdata;
    logic [31:0] d64_spkt, d64_sbeat;
    logic [7:0]  d64_tkeep;
    logic        d64_tvalid, d64_tlast, d64_busy, d64_done, d64_perf;

    logic        sel = 1'b0, rnd = 1'b0;
    logic [63:0] tdata_m;
    logic [7:0]  tkeep_m;
    logic        tvalid_m, tlast_m, busy_m, done_m, perf_m;
    logic [31:0] spkt_m, sbeat_m;

    int total = 0, bad = 0;

    axis_packet_gen #(.DATA_WIDTH(32)) d32 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_len_min(cfg_len_min), .cfg_len_max(cfg_len_max), .cfg_len_sweep(cfg_len_sweep),
        .cfg_prbs(cfg_prbs), .cfg_data(cfg_data[15:0]), .cfg_gap(cfg_gap), .cfg_pkt_count(cfg_pkt_count),
        .cfg_last_keep(cfg_last_keep[3:0]), .m00_axis_tdata(d32_tdata), .m00_axis_tkeep(d32_tkeep),
        .m00_axis_tvalid(d32_tvalid), .m00_axis_tready(tready), .m00_axis_tlast(d32_tlast),
        .busy(d32_busy), .done(d32_done), .perf_start(d32_perf),
        .stat_pkt_count(d32_spkt), .stat_beat_count(d32_sbeat)
    );

    axis_packet_gen #(.DATA_WIDTH(64)) d64 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_len_min(cfg_len_min), .cfg_len_max(cfg_len_max), .cfg_len_sweep(cfg_len_sweep),
        .cfg_prbs(cfg_prbs), .cfg_data(cfg_data), .cfg_gap(cfg_gap), .cfg_pkt_count(cfg_pkt_count),
        .cfg_last_keep(cfg_last_keep), .m00_axis_tdata(d64_tdata), .m00_axis_tkeep(d64_tkeep),
        .m00_axis_tvalid(d64_tvalid), .m00_axis_tready(tready), .m00_axis_tlast(d64_tlast),
        .busy(d64_busy), .done(d64_done), .perf_start(d64_perf),
        .stat_pkt_count(d64_spkt), .stat_beat_count(d64_sbeat)
    );

    always_comb begin
        tdata_m  = sel ? d64_tdata : {32'd0, d32_tdata};
        tkeep_m  = sel ? d64_tkeep : {4'd0, d32_tkeep};
        tvalid_m = sel ? d64_tvalid : d32_tvalid;
        tlast_m  = sel ? d64_tlast : d32_tlast;
        busy_m   = sel ? d64_busy : d32_busy;
        done_m   = sel ? d64_done : d32_done;
        perf_m   = sel ? d64_perf : d32_perf;
        spkt_m   = sel ? d64_spkt : d32_spkt;
        sbeat_m  = sel ? d64_sbeat : d32_sbeat;
    end

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int          mon_beat, idle, perf_n;
    bit          in_gap, stall;
    int          lens[$], gaps[$];
    logic [63:0] h_data;
    logic [7:0]  h_keep, kexp, k;
    logic        h_last;
    logic [30:0] model;
    logic [47:0] pay;

    always @(negedge clk) begin
        if (!rst_n || cfg_start) begin
            mon_beat = 0; idle = 0; perf_n = 0; in_gap = 0; stall = 0;
            lens.delete(); gaps.delete();
            model = 31'h7FFFFFFF;
        end else begin
            if (perf_m) perf_n++;
            if (stall) begin
                chk("hold_valid", 64'(tvalid_m), 64'd1);
                chk("hold_data", tdata_m, h_data);
                chk("hold_keep", 64'(tkeep_m), 64'(h_keep));
                chk("hold_last", 64'(tlast_m), 64'(h_last));
            end
            if (in_gap) begin
                if (tvalid_m) begin gaps.push_back(idle); in_gap = 0; end
                else idle++;
            end
            stall = tvalid_m && !tready;
            h_data = tdata_m; h_keep = tkeep_m; h_last = tlast_m;
            if (tvalid_m && tready) begin
                chk("idx", 64'(tdata_m[15:0]), 64'(mon_beat));
                pay = sel ? tdata_m[63:16] : {32'd0, tdata_m[31:16]};
                if (cfg_prbs) begin
                    chk("prbs", 64'(pay), {48'd0, model[15:0]});
                    model = {model[29:0], model[30] ^ model[27]};
                end else
                    chk("data", 64'(pay), 64'(sel ? cfg_data : {32'd0, cfg_data[15:0]}));
                k = sel ? cfg_last_keep : {4'd0, cfg_last_keep[3:0]};
                kexp = sel ? 8'hFF : 8'h0F;
                if (tlast_m && k != 0) kexp = k;
                chk("keep", 64'(tkeep_m), 64'(kexp));
                mon_beat++;
                if (tlast_m) begin
                    lens.push_back(mon_beat);
                    mon_beat = 0; in_gap = 1; idle = 0;
                end
            end
        end
    end

    task automatic go(input logic [15:0] lmin, input logic [15:0] lmax, input logic sw, input logic pr,
                      input logic [47:0] d, input logic [15:0] g, input logic [31:0] n, input logic [7:0] kp);
        @(posedge clk); #1;
        cfg_len_min = lmin; cfg_len_max = lmax; cfg_len_sweep = sw; cfg_prbs = pr;
        cfg_data = d; cfg_gap = g; cfg_pkt_count = n; cfg_last_keep = kp; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy_m; i++) @(negedge clk);
        chk("idle", 64'(busy_m), 64'd0);
    endtask

    task automatic wait_beat(input int np, input int idx, input int max);
        for (int i = 0; i < max && !(tvalid_m && tready && tdata_m[15:0] == 16'(idx) && lens.size() == np); i++)
            @(negedge clk);
        chk("reach", 64'(tdata_m[15:0]), 64'(idx));
    endtask

    int exp2[5] = '{2, 3, 4, 2, 3};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(tvalid_m), 64'd0);
        chk("rst_valid64", 64'(d64_tvalid), 64'd0);
        chk("rst_data", tdata_m, 64'd0);
        chk("rst_keep", 64'(tkeep_m), 64'd0);
        chk("rst_last", 64'(tlast_m), 64'd0);
        chk("rst_busy", 64'(busy_m), 64'd0);
        chk("rst_done", 64'(done_m), 64'd0);
        chk("rst_perf", 64'(perf_m), 64'd0);
        chk("rst_spkt", 64'(spkt_m), 64'd0);
        chk("rst_sbeat", 64'(sbeat_m), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        go(4, 4, 0, 0, 48'hABCD, 0, 3, 0);
        wait_idle(200);
        chk("t1_done", 64'(done_m), 64'd1);
        chk("t1_spkt", 64'(spkt_m), 64'd3);
        chk("t1_sbeat", 64'(sbeat_m), 64'd12);
        chk("t1_perf", 64'(perf_n), 64'd3);
        chk("t1_npkt", 64'(lens.size()), 64'd3);
        foreach (lens[i]) chk("t1_len", 64'(lens[i]), 64'd4);
        chk("t1_ngap", 64'(gaps.size()), 64'd2);
        foreach (gaps[i]) chk("t1_gap", 64'(gaps[i]), 64'd0);

        go(2, 4, 1, 0, 48'h5A5A, 0, 5, 0);
        wait_idle(200);
        chk("t2_npkt", 64'(lens.size()), 64'd5);
        for (int i = 0; i < 5; i++) chk("t2_len", 64'(lens[i]), 64'(exp2[i]));
        chk("t2_sbeat", 64'(sbeat_m), 64'd14);

        go(2, 2, 0, 0, 48'h0, 3, 2, 0);
        wait_idle(200);
        chk("t3_npkt", 64'(lens.size()), 64'd2);
        chk("t3_ngap", 64'(gaps.size()), 64'd1);
        chk("t3_gap", 64'(gaps[0]), 64'd3);

        sel = 1'b1; rnd = 1'b1;
        go(5, 5, 0, 0, 48'h123456789ABC, 0, 4, 8'h0F);
        wait_idle(500);
        chk("t4_done", 64'(done_m), 64'd1);
        chk("t4_spkt", 64'(spkt_m), 64'd4);
        chk("t4_sbeat", 64'(sbeat_m), 64'd20);
        chk("t4_npkt", 64'(lens.size()), 64'd4);
        foreach (lens[i]) chk("t4_len", 64'(lens[i]), 64'd5);
        sel = 1'b0;

        go(4, 4, 0, 1, 48'h0, 0, 3, 0);
        wait_idle(500);
        chk("t5_sbeat", 64'(sbeat_m), 64'd12);
        rnd = 1'b0;

        go(0, 0, 0, 0, 48'h0F0F, 0, 2, 0);
        wait_idle(100);
        chk("t6_npkt", 64'(lens.size()), 64'd2);
        chk("t6_len0", 64'(lens[0]), 64'd1);
        chk("t6_len1", 64'(lens[1]), 64'd1);
        chk("t6_sbeat", 64'(sbeat_m), 64'd2);

        go(8, 8, 0, 0, 48'h7777, 0, 0, 0);
        wait_beat(1, 3, 100);
        @(posedge clk); #1 cfg_stop = 1'b1;
        @(posedge clk); #1 cfg_stop = 1'b0;
        wait_idle(100);
        chk("t7_done", 64'(done_m), 64'd0);
        chk("t7_npkt", 64'(lens.size()), 64'd2);
        chk("t7_len0", 64'(lens[0]), 64'd8);
        chk("t7_len1", 64'(lens[1]), 64'd8);
        chk("t7_spkt", 64'(spkt_m), 64'd2);
        chk("t7_sbeat", 64'(sbeat_m), 64'd16);

        go(8, 8, 0, 0, 48'h7777, 0, 0, 0);
        wait_beat(0, 5, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_valid", 64'(tvalid_m), 64'd0);
        chk("t8_valid64", 64'(d64_tvalid), 64'd0);
        chk("t8_busy", 64'(busy_m), 64'd0);
        chk("t8_spkt", 64'(spkt_m), 64'd0);
        chk("t8_sbeat", 64'(sbeat_m), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
